// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and default sizing for the fifo_arb slice.
//   rd_state_e      : read-side sequencer states (IDLE / VALID / SETTLE)
//   *_DEF constants : default data width, depth and pointer width
package fifo_arb_pkg;

  localparam int FIFO_WIDTH_DEF   = 8;
  localparam int FIFO_DEPTH_DEF   = 8;
  localparam int POINTER_BITS_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VALID  = 2'd1,
    S_SETTLE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_arb_fifo.sv
// fifo: single-clock synchronous FIFO with a registered read-data output.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (pointers, count, output)
//   wr       in   push data_in (ignored when full)
//   rd       in   pop head (ignored when empty)
//   data_in  in   write data
//   data_out out  registered copy of the head entry
//   full     out  count == FIFO_DEPTH
//   empty    out  count == 0
module fifo
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH   = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int POINTER_BITS = POINTER_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [POINTER_BITS:0] COUNT_FULL = (POINTER_BITS+1)'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [POINTER_BITS-1:0] wr_ptr_q;
  logic [POINTER_BITS-1:0] rd_ptr_q;
  logic [POINTER_BITS:0]   count_q;
  logic [FIFO_WIDTH-1:0]   dout_q;
  logic                    wr_ok;
  logic                    rd_ok;

  assign full     = (count_q == COUNT_FULL);
  assign empty    = (count_q == '0);
  assign wr_ok    = wr && !full;
  assign rd_ok    = rd && !empty;
  assign data_out = dout_q;

  // Storage has no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Output tracks the current head whenever one exists, so it is stable
      // while the head is held and refreshes one cycle after a pop.
      if (!empty) begin
        dout_q <= mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: rtl/fifo_arb.sv
// fifo_arb: two-requester write arbiter and valid/ready read sequencer
// around one fifo instance.
//   clk, rst          clock; synchronous active-high reset
//   flush             synchronous discard of all FIFO contents
//   req0/data0/gnt0   requester 0 write port (gnt = word accepted this cycle)
//   req1/data1/gnt1   requester 1 write port
//   m_valid/m_ready   consumer handshake; m_data is the FIFO head
//   full, empty       internal FIFO status for the current cycle
// Build option FIFO_ARB_FIXED_PRIO_EN: requester 0 always wins ties and the
// round-robin 'last' register is dropped. Undefined: round-robin.
module fifo_arb
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH   = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int POINTER_BITS = POINTER_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req0,
  input  logic [FIFO_WIDTH-1:0] data0,
  output logic                  gnt0,
  input  logic                  req1,
  input  logic [FIFO_WIDTH-1:0] data1,
  output logic                  gnt1,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  full,
  output logic                  empty
);

  logic                  fifo_rst;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic [FIFO_WIDTH-1:0] fifo_din;
  logic [FIFO_WIDTH-1:0] fifo_dout;
  logic                  can_wr;
  rd_state_e             state_q;
  rd_state_e             state_d;

  assign fifo_rst = rst || flush;
  assign can_wr   = !(rst || flush || full);

  fifo #(
    .FIFO_WIDTH  (FIFO_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .POINTER_BITS(POINTER_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (fifo_rst),
    .wr      (fifo_wr),
    .rd      (fifo_rd),
    .data_in (fifo_din),
    .data_out(fifo_dout),
    .full    (full),
    .empty   (empty)
  );

  // ---------------- write arbitration ----------------
`ifdef FIFO_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = can_wr && req0;
    gnt1 = can_wr && req1 && !req0;
  end
`else
  // last_q = 1 means requester 1 was granted most recently, so 0 wins a tie.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt0   = can_wr && req0 && (!req1 || last_q);
    gnt1   = can_wr && req1 && (!req0 || !last_q);
    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign fifo_wr  = gnt0 || gnt1;
  assign fifo_din = gnt1 ? data1 : data0;

  // ---------------- read sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // SETTLE is the bubble that lets the FIFO's registered output catch up
  // with the head after a pop, so m_data is never stale while m_valid=1.
  always_comb begin
    state_d = state_q;
    m_valid = 1'b0;
    fifo_rd = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        m_valid = 1'b1;
        if (m_ready) begin
          fifo_rd = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        state_d = empty ? S_IDLE : S_VALID;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_data = fifo_dout;

endmodule

// File: tb/tb_fifo_arb.sv
module tb_fifo_arb;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst, flush, req0, req1, m_ready;
  logic [W-1:0] data0, data1;
  logic         gnt0, gnt1, m_valid, full, empty;
  logic [W-1:0] m_data;

  fifo_arb #(
    .FIFO_WIDTH  (W),
    .FIFO_DEPTH  (D),
    .POINTER_BITS(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .req0   (req0),
    .data0  (data0),
    .gnt0   (gnt0),
    .req1   (req1),
    .data1  (data1),
    .gnt1   (gnt1),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .full   (full),
    .empty  (empty)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Reference model: contents as a queue, tie-break memory, and whether the
  // head is being presented to the consumer this cycle.
  logic [W-1:0] mq[$];
  logic         m_last = 1'b1;
  logic         m_vis  = 1'b0;
  int unsigned  n0 = 0;
  int unsigned  n1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: check outputs at the falling edge, then advance model.
  task automatic step();
    logic blocked, e_g0, e_g1, pop, nvis;
    @(negedge clk);
    blocked = rst || flush || (mq.size() == D);
`ifdef FIFO_ARB_FIXED_PRIO_EN
    e_g0 = !blocked && req0;
    e_g1 = !blocked && req1 && !req0;
`else
    e_g0 = !blocked && req0 && (!req1 || m_last);
    e_g1 = !blocked && req1 && (!req0 || !m_last);
`endif
    check("gnt0", gnt0, e_g0);
    check("gnt1", gnt1, e_g1);
    check("m_valid", m_valid, m_vis);
    check("full", full, mq.size() == D);
    check("empty", empty, mq.size() == 0);
    if (m_vis) check("m_data", m_data, mq[0]);

    pop = m_vis && m_ready;
    if (rst || flush) begin
      mq.delete();
      m_last = 1'b1;
      m_vis  = 1'b0;
    end else begin
      // a pop costs one bubble; an idle head shows up the cycle after it exists
      nvis = m_vis ? !pop : (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (e_g0) begin mq.push_back(data0); m_last = 1'b0; n0++; end
      if (e_g1) begin mq.push_back(data1); m_last = 1'b1; n1++; end
      m_vis = nvis;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req0 = 1'b0; req1 = 1'b0;
    data0 = '0; data1 = '0; m_ready = 1'b0;
    @(posedge clk);
    #1;
    step();
    check("reset_m_data", m_data, 32'h0);
    rst = 1'b0;

    // single word A5: visible two cycles after grant, then popped
    req0 = 1'b1; data0 = 8'hA5;
    step();
    req0 = 1'b0;
    repeat (3) step();
    m_ready = 1'b1;
    repeat (3) step();
    m_ready = 1'b0;

    // both requesting: alternation, fill to full, grants stop
    n0 = 0; n1 = 0;
    req0 = 1'b1; req1 = 1'b1;
    repeat (12) begin
      data0 = 8'(32'h10 + n0);
      data1 = 8'(32'h20 + n1);
      step();
    end
    // single pop while still requesting: full clears, next req granted
    m_ready = 1'b1;
    data0 = 8'(32'h10 + n0); data1 = 8'(32'h20 + n1);
    step();
    m_ready = 1'b0;
    repeat (3) begin
      data0 = 8'(32'h10 + n0);
      data1 = 8'(32'h20 + n1);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    m_ready = 1'b1;
    repeat (20) step();

    // four words preloaded, then drain with m_ready held high
    m_ready = 1'b0;
    req0 = 1'b1;
    repeat (4) begin
      data0 = 8'($urandom);
      step();
    end
    req0 = 1'b0;
    m_ready = 1'b1;
    repeat (10) step();

    // hold head for 10 cycles with concurrent writes, then flush
    m_ready = 1'b0;
    req0 = 1'b1;
    repeat (5) begin
      data0 = 8'($urandom);
      step();
    end
    req0 = 1'b0;
    repeat (3) step();
    repeat (10) begin
      req1  = 1'($urandom_range(0, 1));
      data1 = 8'($urandom);
      step();
    end
    req1 = 1'b0;
    flush = 1'b1; req0 = 1'b1; data0 = 8'h77;
    step();
    flush = 1'b0; req0 = 1'b0;
    repeat (2) step();

    // randomized traffic
    repeat (400) begin
      req0    = 1'($urandom_range(0, 1));
      req1    = 1'($urandom_range(0, 1));
      data0   = 8'($urandom);
      data1   = 8'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 31) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; req0 = 1'b0; req1 = 1'b0; m_ready = 1'b1;
    repeat (20) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifo_arb.md
# fifo_arb

Two-requester write arbiter and read sequencer around one `fifo` instance. Shares the FIFO write port between two producers, for example the CPU store path and a DMA/peripheral path. Guards against pushing when full. Converts the FIFO's unguarded `rd` pulse and one-cycle registered read data into a valid/ready stream for a single consumer. Sits between the bus-side producers and a UART/peripheral consumer.

## Interface
Parameters:
- FIFO_WIDTH, 8, data width of every data port
- FIFO_DEPTH, 8, entries in the internal FIFO (power of two)
- POINTER_BITS, 3, log2(FIFO_DEPTH)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all FIFO contents
- req0  in  1  requester 0 write request
- data0  in  FIFO_WIDTH  requester 0 write data
- gnt0  out  1  requester 0 word accepted this cycle
- req1  in  1  requester 1 write request
- data1  in  FIFO_WIDTH  requester 1 write data
- gnt1  out  1  requester 1 word accepted this cycle
- m_valid  out  1  m_data holds the FIFO head
- m_ready  in  1  consumer takes the head when m_valid & m_ready
- m_data  out  FIFO_WIDTH  head-of-FIFO data
- full  out  1  internal FIFO full
- empty  out  1  internal FIFO empty

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- Internal `fifo` reset = rst | flush. Its wr/rd are driven only by this block.
- Write arbitration (combinational grant, registered pointer):
  - At most one gnt per cycle.
  - No gnt while full.
  - gntN implies fifo wr=1 with dataN that cycle.
  - Both requesting: grant the requester not granted last; `last` register updates on every grant.
  - One requesting: it wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- Write during the pop cycle is allowed. full/empty are those of the FIFO for the current cycle.
- Read FSM, states IDLE, VALID, SETTLE:
  - IDLE: m_valid=0. If !empty, go to VALID. On that edge the FIFO registers memory[rd_ptr] into its output.
  - VALID: m_valid=1, m_data = FIFO output. When m_ready, pulse fifo rd=1 for exactly that cycle and go to SETTLE. Otherwise hold; m_data stays stable.
  - SETTLE: m_valid=0, rd=0. One bubble while the FIFO output refreshes to the new head. If !empty go to VALID, else go to IDLE.
- rd is never asserted outside VALID&m_ready, so it never occurs while empty.
- rst or flush in any state: FSM to IDLE, `last`=1, FIFO pointers cleared. Any in-flight m_valid drops the next cycle. Grants in a flush cycle are suppressed: gnt0=gnt1=0 while flush or rst.

## Timing
- Reset values: m_valid=0, gnt0=gnt1=0, m_data=0, empty=1, full=0, FSM=IDLE.
- Write-to-visible latency: gnt at edge T, empty falls after T, VALID entered at T+1, m_valid=1 in cycle T+1..
- Drain throughput is one word per 2 cycles (VALID then SETTLE).
- Write throughput is one word per cycle while !full.
- Simultaneous grant and pop while full: no grant that cycle; full clears the next cycle.

## Configuration
- FIFO_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties. The `last` register is removed and gnt1 requires !req0.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

## Structure
- Shared d16 include holds the FSM state localparams S_IDLE=2'd0, S_VALID=2'd1, S_SETTLE=2'd2, and the default width/depth constants.
- One sub-module: the existing `fifo`, instantiated once. Arbitration and FSM live in fifo_arb itself.

## Test plan
- Reset then req0=1, data0=8'hA5 for one cycle: gnt0=1 that cycle; m_valid=1 two cycles later with m_data=8'hA5. m_ready=1 pops it; m_valid=0 the next cycle; empty=1.
- req0 and req1 held high with data0=8'h10+n, data1=8'h20+n:
  - Grants alternate 0,1,0,1…
  - Drained sequence is 10,20,11,21…
  - With FIFO_ARB_FIXED_PRIO_EN: only 10,11,12… until req0 drops.
- Fill 8 words with m_ready=0: full=1; further reqs get no gnt. A single pop clears full, and the next req is granted.
- m_ready held high, 4 words pre-loaded: m_valid pattern 1,0,1,0,1,0,1; rd asserted exactly 4 times; never while empty.
- flush asserted while in VALID with 5 words queued: next cycle m_valid=0, empty=1. Same-cycle req0 not granted.
- m_ready=0 for 10 cycles in VALID: m_data constant; concurrent writes don't alter it.
